// File: rtl/predictor_pkg.sv
// Shared types and helpers for the PHT port arbiter.
//   arb_state_e  : port sequencer state (idle / update write-back)
//   upd_entry_t  : queued branch-resolution update {index, outcome}
//   sat_update() : saturating up/down step of an N-bit counter
package predictor_pkg;

  // Widest PHT index the update-entry struct can carry; narrower tables
  // zero-extend into it.
  localparam int unsigned IDX_W_MAX = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPD_WR = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] index;
    logic                 outcome;
  } upd_entry_t;

  // Taken moves the counter towards max_val, not-taken towards zero; both ends stick.
  function automatic int unsigned sat_update(input int unsigned value,
                                             input logic        outcome,
                                             input int unsigned max_val);
    if (outcome) begin
      return (value >= max_val) ? max_val : value + 32'd1;
    end
    return (value == 32'd0) ? 32'd0 : value - 32'd1;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Synchronous FIFO holding pending PHT updates.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push/wdata : enqueue; ignored while full, even if a pop happens that cycle
//   pop        : dequeue the head; ignored while empty
//   rdata      : current head entry (valid while !empty)
//   full/empty : occupancy flags
module pht_update_fifo #(
  parameter int WIDTH  = 5,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(QDEPTH);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pht_port_arbiter.sv
// Sequencer/arbiter for a single-ported PHT of 2^K N-bit saturating counters.
// Shares the one synchronous-read RAM port between two round-robin lookup
// requesters and a queue of branch-resolution updates; each update is a
// read followed by a write of the saturated value.
//   lk_valid/lk_index/lk_ready : lookup requests and one-hot grant (combinational)
//   pred_valid/prediction      : lookup result, one cycle after the grant
//   upd_valid/upd_index/upd_outcome/upd_ready : update queue push side
//   pht_en/pht_we/pht_addr/pht_wdata/pht_rdata : RAM port
module pht_port_arbiter
  import predictor_pkg::*;
#(
  parameter int K          = 4,
  parameter int N          = 2,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     lk_valid,
  input  logic [2*K-1:0] lk_index,
  output logic [1:0]     lk_ready,
  output logic [1:0]     pred_valid,
  output logic [1:0]     prediction,
  input  logic           upd_valid,
  input  logic [K-1:0]   upd_index,
  input  logic           upd_outcome,
  output logic           upd_ready,
  output logic           pht_en,
  output logic           pht_we,
  output logic [K-1:0]   pht_addr,
  output logic [N-1:0]   pht_wdata,
  input  logic [N-1:0]   pht_rdata
);

  localparam int          SW      = $clog2(STARVE_MAX + 1);
  localparam int unsigned CNT_MAX = (32'd1 << N) - 32'd1;

  arb_state_e state;
  logic       rr_ptr;
  logic [SW-1:0] starve_cnt;

  logic [1:0] lk_gnt_p1;
  upd_entry_t upd_hold_p1;

  logic [K:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       upd_push;

  logic       any_lk;
  logic       force_upd;
  logic       start_upd;
  logic       grant_lk;
  logic       grant_sel;
  logic [1:0] grant_vec;

  assign upd_ready = !reset && !fifo_full;
  assign upd_push  = upd_valid && upd_ready;

  pht_update_fifo #(
    .WIDTH  (K + 1),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (upd_push),
    .wdata ({upd_index, upd_outcome}),
    .pop   (start_upd),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Port arbitration: a full queue or a starved head beats lookups;
  // otherwise lookups win and the queue only drains on otherwise idle cycles.
  always_comb begin
    any_lk    = |lk_valid;
    force_upd = fifo_full || (!fifo_empty && (starve_cnt >= SW'(STARVE_MAX)));
    start_upd = 1'b0;
    grant_lk  = 1'b0;
    if (!reset && (state == ST_IDLE)) begin
      if (force_upd)        start_upd = 1'b1;
      else if (any_lk)      grant_lk  = 1'b1;
      else if (!fifo_empty) start_upd = 1'b1;
    end
    // Pointer only matters on contention; a lone requester always wins.
    grant_sel = (lk_valid == 2'b11) ? rr_ptr : lk_valid[1];
    grant_vec = 2'b00;
    if (grant_lk) grant_vec[grant_sel] = 1'b1;
  end

  assign lk_ready = grant_vec;

  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = '0;
    if (!reset) begin
      if (state == ST_UPD_WR) begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = K'(upd_hold_p1.index);
        pht_wdata = N'(sat_update(32'(pht_rdata), upd_hold_p1.outcome, CNT_MAX));
      end else if (start_upd) begin
        pht_en   = 1'b1;
        pht_addr = fifo_head[K:1];
      end else if (grant_lk) begin
        pht_en   = 1'b1;
        pht_addr = grant_sel ? lk_index[2*K-1:K] : lk_index[K-1:0];
      end
    end
  end

  // The RAM returns data one cycle after the read, so the result is steered
  // to whichever requester was granted on the previous cycle.
  assign pred_valid = reset ? 2'b00 : lk_gnt_p1;
  assign prediction = pred_valid & {2{pht_rdata[N-1]}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
      lk_gnt_p1  <= 2'b00;
    end else begin
      lk_gnt_p1 <= grant_vec;
      if (grant_lk) rr_ptr <= ~grant_sel;
      case (state)
        ST_IDLE:   if (start_upd) state <= ST_UPD_WR;
        ST_UPD_WR: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      if (state == ST_IDLE) begin
        if (fifo_empty || start_upd)
          starve_cnt <= '0;
        else if (starve_cnt < SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // ---- p1: update read issued -> write-back with the returned data ----
  always_ff @(posedge clk) begin
    if (start_upd)
      upd_hold_p1 <= '{index: IDX_W_MAX'(fifo_head[K:1]), outcome: fifo_head[0]};
  end

endmodule

// File: tb/tb_pht_port_arbiter.sv
// Self-checking bench for pht_port_arbiter with a behavioural PHT RAM.
module tb_pht_port_arbiter;

  localparam int K          = 4;
  localparam int N          = 2;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     lk_valid;
  logic [2*K-1:0] lk_index;
  logic [1:0]     lk_ready;
  logic [1:0]     pred_valid;
  logic [1:0]     prediction;
  logic           upd_valid;
  logic [K-1:0]   upd_index;
  logic           upd_outcome;
  logic           upd_ready;
  logic           pht_en;
  logic           pht_we;
  logic [K-1:0]   pht_addr;
  logic [N-1:0]   pht_wdata;
  logic [N-1:0]   pht_rdata;

  always #5 clk = ~clk;

  pht_port_arbiter #(
    .K(K), .N(N), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lk_valid    (lk_valid),
    .lk_index    (lk_index),
    .lk_ready    (lk_ready),
    .pred_valid  (pred_valid),
    .prediction  (prediction),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .upd_outcome (upd_outcome),
    .upd_ready   (upd_ready),
    .pht_en      (pht_en),
    .pht_we      (pht_we),
    .pht_addr    (pht_addr),
    .pht_wdata   (pht_wdata),
    .pht_rdata   (pht_rdata)
  );

  // Synchronous-read single-port PHT storage.
  logic [N-1:0] ram [16];
  always @(posedge clk) begin
    if (pht_en) begin
      if (pht_we) ram[pht_addr] <= pht_wdata;
      else        pht_rdata     <= ram[pht_addr];
    end
  end

  typedef struct { int req; int pred; } pred_exp_t;
  typedef struct { int addr; int data; } wr_exp_t;
  pred_exp_t exp_pred[$];
  wr_exp_t   exp_wr[$];
  int        ref_tbl[16];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sat(input int v, input int o);
    int mx;
    mx = (1 << N) - 1;
    if (o != 0) return (v >= mx) ? mx : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Record the prediction the bench's own table says a granted lookup must return.
  task automatic note_grant();
    int idx;
    check_val("grant_onehot", ($countones(lk_ready) <= 1), 1);
    for (int i = 0; i < 2; i++) begin
      if (lk_ready[i]) begin
        idx = (i == 0) ? int'(lk_index[K-1:0]) : int'(lk_index[2*K-1:K]);
        exp_pred.push_back('{req: i, pred: (ref_tbl[idx] >> (N - 1)) & 1});
      end
    end
  endtask

  task automatic expect_upd(input int idx, input int o);
    int nv;
    nv = ref_sat(ref_tbl[idx], o);
    ref_tbl[idx] = nv;
    exp_wr.push_back('{addr: idx, data: nv});
  endtask

  // Scoreboard side: pop and compare whenever the DUT produces a result.
  pred_exp_t mon_pe;
  wr_exp_t   mon_we;
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (pred_valid[i]) begin
          if (exp_pred.size() == 0) begin
            check_val("pred_unexpected", 1, 0);
          end else begin
            mon_pe = exp_pred.pop_front();
            check_val("pred_req", i, mon_pe.req);
            check_val("pred_val", prediction[i], mon_pe.pred);
          end
        end
      end
      if (pht_en && pht_we) begin
        if (exp_wr.size() == 0) begin
          check_val("write_unexpected", 1, 0);
        end else begin
          mon_we = exp_wr.pop_front();
          check_val("wr_addr", pht_addr, mon_we.addr);
          check_val("wr_data", pht_wdata, mon_we.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit found;

    for (int i = 0; i < 16; i++) ram[i] = N'(i % 4);
    ram[5] = 2'd3;
    ram[2] = 2'd0;
    ram[7] = 2'd1;
    for (int i = 0; i < 16; i++) ref_tbl[i] = int'(ram[i]);

    // Reset with live requests on every input: everything must stay quiet.
    reset       = 1'b1;
    lk_valid    = 2'b11;
    lk_index    = {4'd4, 4'd3};
    upd_valid   = 1'b1;
    upd_index   = 4'd1;
    upd_outcome = 1'b1;
    repeat (3) step();
    settle();
    check_val("rst_lk_ready", lk_ready, 0);
    check_val("rst_pred_valid", pred_valid, 0);
    check_val("rst_prediction", prediction, 0);
    check_val("rst_pht_en", pht_en, 0);
    check_val("rst_pht_we", pht_we, 0);
    check_val("rst_pht_addr", pht_addr, 0);
    check_val("rst_pht_wdata", pht_wdata, 0);
    check_val("rst_upd_ready", upd_ready, 0);

    step();
    reset     = 1'b0;
    lk_valid  = 2'b00;
    upd_valid = 1'b0;
    settle();
    check_val("idle_pht_en", pht_en, 0);
    check_val("idle_upd_ready", upd_ready, 1);

    // Round-robin under contention, queue empty.
    step();
    lk_valid = 2'b11;
    lk_index = {4'd4, 4'd3};
    for (int c = 0; c < 6; c++) begin
      settle();
      check_val("rr_grant", lk_ready, (c % 2 == 0) ? 1 : 2);
      check_val("rr_addr", pht_addr, (c % 2 == 0) ? 3 : 4);
      check_val("rr_rd", {pht_en, pht_we}, 2'b10);
      note_grant();
      step();
    end
    lk_valid = 2'b00;
    step();
    step();

    // Saturation at both ends.
    upd_valid   = 1'b1;
    upd_index   = 4'd5;
    upd_outcome = 1'b1;
    settle();
    check_val("u5_ready", upd_ready, 1);
    expect_upd(5, 1);
    step();
    upd_index   = 4'd2;
    upd_outcome = 1'b0;
    settle();
    check_val("u2_ready", upd_ready, 1);
    expect_upd(2, 0);
    step();
    upd_valid = 1'b0;
    repeat (6) step();

    // Update latency and read-after-write visibility.
    upd_valid   = 1'b1;
    upd_index   = 4'd7;
    upd_outcome = 1'b1;
    settle();
    expect_upd(7, 1);
    step();
    upd_valid = 1'b0;
    settle();
    check_val("u7_rd", {pht_en, pht_we}, 2'b10);
    check_val("u7_rd_addr", pht_addr, 7);
    step();
    settle();
    check_val("u7_wr", {pht_en, pht_we}, 2'b11);
    check_val("u7_wr_data", pht_wdata, 2);
    step();
    lk_valid = 2'b01;
    lk_index = {4'd0, 4'd7};
    settle();
    check_val("lk7_grant", lk_ready, 1);
    note_grant();
    step();
    lk_valid = 2'b00;
    settle();
    check_val("lk7_pred", prediction, 2'b01);
    step();

    // Starvation bound under continuous lookups.
    lk_valid    = 2'b11;
    lk_index    = {4'd1, 4'd0};
    upd_valid   = 1'b1;
    upd_index   = 4'd9;
    upd_outcome = 1'b1;
    settle();
    check_val("u9_ready", upd_ready, 1);
    expect_upd(9, 1);
    note_grant();
    step();
    upd_valid = 1'b0;
    gap   = 0;
    found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      settle();
      if (pht_en && !pht_we && lk_ready == 2'b00) begin
        found = 1'b1;
        gap   = c;
        check_val("starve_addr", pht_addr, 9);
      end else begin
        note_grant();
      end
      step();
    end
    check_val("starve_gap", gap, STARVE_MAX + 1);
    settle();
    check_val("starve_wr_nolk", lk_ready, 0);
    check_val("starve_wr", {pht_en, pht_we}, 2'b11);
    step();
    lk_valid = 2'b00;
    step();
    step();

    // Fill the queue under continuous lookups; full forces an update.
    lk_valid = 2'b11;
    lk_index = {4'd1, 4'd0};
    for (int j = 0; j < 4; j++) begin
      upd_valid   = 1'b1;
      upd_index   = K'(10 + j);
      upd_outcome = (j % 2 == 0);
      settle();
      check_val("fill_ready", upd_ready, 1);
      expect_upd(10 + j, (j % 2 == 0) ? 1 : 0);
      note_grant();
      step();
    end
    upd_index   = 4'd14;
    upd_outcome = 1'b1;
    settle();
    check_val("full_ready", upd_ready, 0);
    check_val("full_lk_ready", lk_ready, 0);
    check_val("full_rd", {pht_en, pht_we}, 2'b10);
    check_val("full_addr", pht_addr, 10);
    step();
    upd_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      settle();
      note_grant();
      step();
    end
    lk_valid = 2'b00;
    repeat (10) step();

    // Reset in the middle of a read-modify-write.
    upd_valid   = 1'b1;
    upd_index   = 4'd6;
    upd_outcome = 1'b0;
    settle();
    check_val("r6_ready", upd_ready, 1);
    step();
    upd_index   = 4'd8;
    upd_outcome = 1'b1;
    settle();
    check_val("r6_rd_addr", pht_addr, 6);
    step();
    upd_valid = 1'b0;
    reset     = 1'b1;
    settle();
    check_val("rwr_pht_en", pht_en, 0);
    check_val("rwr_pht_we", pht_we, 0);
    check_val("rwr_wdata", pht_wdata, 0);
    check_val("rwr_upd_ready", upd_ready, 0);
    step();
    step();
    reset = 1'b0;
    settle();
    check_val("post_rst_idle", pht_en, 0);
    check_val("post_rst_ready", upd_ready, 1);
    step();
    lk_valid = 2'b11;
    lk_index = {4'd8, 4'd6};
    settle();
    check_val("post_rst_rr", lk_ready, 1);
    check_val("post_rst_addr", pht_addr, 6);
    note_grant();
    step();
    lk_valid = 2'b00;
    settle();
    check_val("post_rst_pred6", prediction, 2'b01);
    repeat (5) step();

    check_val("pred_queue_drained", exp_pred.size(), 0);
    check_val("wr_queue_drained", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
